// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache fetches and dcache reads/writes onto one RAM port.
// Optional MEMARB_STATS_EN adds icount/dcount completion counters.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int DSTREAK_MAX = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);
  localparam int SW = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(DSTREAK_MAX);
  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;
  state_t            state, next_state;
  logic [SW-1:0]     dstreak, next_dstreak;
  logic [ADDR_W-1:0] laddr, next_laddr;
  logic [WORD_W-1:0] ldata, next_ldata;
  logic              own, done;
  // state, streak counter and latched request registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      laddr   <= '0;
      ldata   <= '0;
    end else begin
      state   <= next_state;
      dstreak <= next_dstreak;
      laddr   <= next_laddr;
      ldata   <= next_ldata;
    end
  end
  // arbitration, completion/abort/retry handling and RAM/cache outputs
  always_comb begin
    own = (state == IREAD) ? iREN : (state == DREAD) ? dREN : (state == DWRITE) ? dWEN : 1'b0;
    done = own && (ramstate == 2'd2);
    next_state = state;
    next_dstreak = dstreak;
    next_laddr = laddr;
    next_ldata = ldata;
    ramREN = own && (state == IREAD || state == DREAD);
    ramWEN = own && (state == DWRITE);
    ramaddr = (state != IDLE) ? laddr : '0;
    ramstore = (state == DWRITE) ? ldata : '0;
    iwait = !(done && state == IREAD);
    dwait = !(done && state != IREAD);
    iload = iwait ? '0 : ramload;
    dload = dwait ? '0 : ramload;
    if (state == IDLE) begin
      if (dstreak == SMAX && iREN) begin
        next_state = IREAD;
        next_laddr = iaddr;
      end else if (dWEN) begin
        next_state = DWRITE;
        next_laddr = daddr;
        next_ldata = dstore;
      end else if (dREN) begin
        next_state = DREAD;
        next_laddr = daddr;
      end else if (iREN) begin
        next_state = IREAD;
        next_laddr = iaddr;
      end
    end else if (!own || ramstate == 2'd3) begin
      next_state = IDLE;
    end else if (done) begin
      next_state = IDLE;
      next_dstreak = (state != IREAD && iREN) ? ((dstreak == SMAX) ? dstreak : dstreak + SW'(1)) : '0;
    end
  end
`ifdef MEMARB_STATS_EN
  // completion counters, wrapping naturally at 32 bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      icount <= icount + 32'(!iwait);
      dcount <= dcount + 32'(!dwait);
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int          total = 0, passed = 0, fails = 0;
  logic [5:0]  pat = 6'b011011;
`ifdef MEMARB_STATS_EN
  logic [31:0] icount, dcount;
`endif

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMARB_STATS_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload, 32'd0);
    nRST = 1'b1;
    // instruction fetch: BUSY, BUSY, ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1; ramload = 32'hDEADBEEF;
    #1;
    chk("t1_idle_ramREN", {31'd0, ramREN}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) ramstate = 2'd2;
      #1;
      chk("t1_ramREN", {31'd0, ramREN}, 32'd1);
      chk("t1_ramaddr", ramaddr, 32'h40);
      chk("t1_iwait", {31'd0, iwait}, (i == 2) ? 32'd0 : 32'd1);
      chk("t1_dwait", {31'd0, dwait}, 32'd1);
    end
    chk("t1_iload", iload, 32'hDEADBEEF);
    cyc();
    iREN = 1'b0; ramstate = 2'd0;
    #1;
    chk("t1_back_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t1_back_idle_iwait", {31'd0, iwait}, 32'd1);
    // simultaneous iREN and dWEN: write first
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
    ramstate = 2'd2; ramload = 32'hCAFEF00D;
    cyc();
    chk("t2_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("t2_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t2_ramaddr", ramaddr, 32'h80);
    chk("t2_ramstore", ramstore, 32'h12345678);
    chk("t2_dwait", {31'd0, dwait}, 32'd0);
    chk("t2_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    dWEN = 1'b0;
    #1;
    chk("t2_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t2_idle_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    chk("t2_i_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t2_i_ramaddr", ramaddr, 32'h44);
    chk("t2_i_iwait", {31'd0, iwait}, 32'd0);
    chk("t2_i_iload", iload, 32'hCAFEF00D);
    chk("t2_i_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    iREN = 1'b0;
    // continuous iREN+dREN: D,D,I,D,D,I
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_ramaddr", ramaddr, pat[i] ? 32'h200 : 32'h300);
      chk("t3_dwait", {31'd0, dwait}, pat[i] ? 32'd0 : 32'd1);
      chk("t3_iwait", {31'd0, iwait}, pat[i] ? 32'd1 : 32'd0);
      cyc();
      chk("t3_idle_ramREN", {31'd0, ramREN}, 32'd0);
    end
    iREN = 1'b0; dREN = 1'b0;
    cyc();
    // data read with one ERROR then ACCESS
    dREN = 1'b1; daddr = 32'h100; ramstate = 2'd3; ramload = 32'h11111111;
    cyc();
    chk("t4_err_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t4_err_ramaddr", ramaddr, 32'h100);
    chk("t4_err_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    ramstate = 2'd2; ramload = 32'hA5A55A5A;
    #1;
    chk("t4_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t4_idle_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    chk("t4_retry_ramaddr", ramaddr, 32'h100);
    chk("t4_retry_dwait", {31'd0, dwait}, 32'd0);
    chk("t4_retry_dload", dload, 32'hA5A55A5A);
    cyc();
    dREN = 1'b0;
    #1;
    chk("t4_after_dwait", {31'd0, dwait}, 32'd1);
    // instruction request withdrawn mid-grant
    iREN = 1'b1; iaddr = 32'h60; ramstate = 2'd1;
    cyc();
    chk("t5_ramREN", {31'd0, ramREN}, 32'd1);
    iREN = 1'b0;
    #1;
    chk("t5_abort_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t5_abort_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    chk("t5_idle_ramREN", {31'd0, ramREN}, 32'd0);
    // reset mid-write
    dWEN = 1'b1; daddr = 32'h90; dstore = 32'h55;
    cyc();
    chk("t6_ramWEN", {31'd0, ramWEN}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("t6_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t6_rst_dwait", {31'd0, dwait}, 32'd1);
    chk("t6_rst_iwait", {31'd0, iwait}, 32'd1);
    chk("t6_rst_ramaddr", ramaddr, 32'd0);
    cyc();
    dWEN = 1'b0; nRST = 1'b1;
    cyc();
    chk("t6_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t6_idle_ramREN", {31'd0, ramREN}, 32'd0);
`ifdef MEMARB_STATS_EN
    chk("st_icount0", icount, 32'd0);
    chk("st_dcount0", dcount, 32'd0);
    ramstate = 2'd2;
    dREN = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    dREN = 1'b0; iREN = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    iREN = 1'b0;
    cyc();
    chk("st_icount", icount, 32'd3);
    chk("st_dcount", dcount, 32'd5);
    nRST = 1'b0;
    #1;
    chk("st_icount_rst", icount, 32'd0);
    chk("st_dcount_rst", dcount, 32'd0);
    nRST = 1'b1;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
